// File: rtl/mem_clear_sequencer.sv
// Zeroes every word of each requested SRAM in one shared sweep.
// Clear requests are rising edges of Clear_Req. Edges that arrive during a sweep
// are queued and served by the following sweep.
module mem_clear_sequencer #(
  parameter int unsigned Nums_SRAM  = 3,
  parameter int unsigned Addr_Width = 4,
  parameter int unsigned Data_Width = 8,
  parameter int unsigned Depth      = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic [Nums_SRAM-1:0]  Clear_Req,
  input  logic                  Stall,
  output logic [Nums_SRAM-1:0]  Wr_En,
  output logic [Addr_Width-1:0] Wr_Addr,
  output logic [Data_Width-1:0] Wr_Data,
  output logic                  Busy,
  output logic                  Done,
  output logic [Nums_SRAM-1:0]  Clear_Status
);

  localparam logic [Addr_Width-1:0] LastAddr = Addr_Width'(Depth - 1);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e                state_q, state_d;
  logic [Addr_Width-1:0] addr_q, addr_d;
  logic [Nums_SRAM-1:0]  req_q;
  logic [Nums_SRAM-1:0]  pending_q, pending_d;
  logic [Nums_SRAM-1:0]  active_q, active_d;
  logic [Nums_SRAM-1:0]  status_q, status_d;
  logic [Nums_SRAM-1:0]  req_edge;

  // A held level counts once: only the 0->1 transition is a request.
  assign req_edge = Clear_Req & ~req_q;

  // State registers; reset abandons any sweep and drops queued requests.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      req_q     <= '0;
      pending_q <= '0;
      active_q  <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      req_q     <= Clear_Req;
      pending_q <= pending_d;
      active_q  <= active_d;
      status_q  <= status_d;
    end
  end

  // Next-state logic and write-port outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    pending_d = pending_q | req_edge;
    active_d  = active_q;
    status_d  = status_q & ~req_edge;
    Wr_En     = '0;
    Done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending_q != '0) begin
          active_d  = pending_q;
          pending_d = req_edge;
          addr_d    = '0;
          state_d   = StSweep;
        end
      end
      StSweep: begin
        if (!Stall) begin
          Wr_En = active_q;
          if (addr_q == LastAddr) begin
            state_d = StDone;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDone: begin
        Done     = 1'b1;
        // An SRAM re-requested during its own sweep is not reported clean.
        status_d = (status_q | (active_q & ~pending_q)) & ~req_edge;
        active_d = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign Wr_Addr      = addr_q;
  assign Wr_Data      = '0;
  assign Busy         = (state_q != StIdle);
  assign Clear_Status = status_q;

endmodule

// File: tb/tb_mem_clear_sequencer.sv
// Directed bench for mem_clear_sequencer with hand-computed expectations.
module tb_mem_clear_sequencer;

  logic       clk = 1'b0;
  logic       Reset;
  logic [2:0] Clear_Req;
  logic       Stall;
  logic [2:0] Wr_En;
  logic [3:0] Wr_Addr;
  logic [7:0] Wr_Data;
  logic       Busy;
  logic       Done;
  logic [2:0] Clear_Status;

  mem_clear_sequencer #(
    .Nums_SRAM (3),
    .Addr_Width(4),
    .Data_Width(8),
    .Depth     (16)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Clear_Req   (Clear_Req),
    .Stall       (Stall),
    .Wr_En       (Wr_En),
    .Wr_Addr     (Wr_Addr),
    .Wr_Data     (Wr_Data),
    .Busy        (Busy),
    .Done        (Done),
    .Clear_Status(Clear_Status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state, cleared on request from the stimulus process.
  int       clr_req = 0;
  int       clr_ack = 0;
  int       wr_cnt [3][16];
  int       wr_cycles, sweep_cyc, data_bad, outside, first_wr, first_addr;
  logic [2:0] sweep_mask[$];
  int       sweep_start[$];
  int       done_at[$];

  always @(negedge clk) begin
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      for (int i = 0; i < 3; i++)
        for (int a = 0; a < 16; a++) wr_cnt[i][a] = 0;
      wr_cycles = 0; sweep_cyc = 0; data_bad = 0; outside = 0;
      first_wr = -1; first_addr = -1;
      sweep_mask.delete(); sweep_start.delete(); done_at.delete();
    end
    if (Wr_En != 3'b000) begin
      wr_cycles++;
      if (first_wr < 0) begin first_wr = cyc; first_addr = int'(Wr_Addr); end
      for (int i = 0; i < 3; i++) if (Wr_En[i]) wr_cnt[i][Wr_Addr]++;
      if (Wr_Addr == 4'd0) begin sweep_mask.push_back(Wr_En); sweep_start.push_back(cyc); end
      if (!Busy || Done) outside++;
    end
    if (Busy && !Done) sweep_cyc++;
    if (Done) done_at.push_back(cyc);
    if (Wr_Data != 8'd0) data_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    clr_req++;
  endtask

  function automatic int once_cnt(input int i);
    int c = 0;
    for (int a = 0; a < 16; a++) if (wr_cnt[i][a] == 1) c++;
    return c;
  endfunction

  function automatic int tot_cnt(input int i);
    int c = 0;
    for (int a = 0; a < 16; a++) c += wr_cnt[i][a];
    return c;
  endfunction

  task automatic do_reset();
    Reset = 1'b1; Clear_Req = 3'b000; Stall = 1'b0;
    step(2);
    Reset = 1'b0;
  endtask

  task automatic pulse_req(input logic [2:0] m);
    Clear_Req = m;
    step(1);
    Clear_Req = 3'b000;
  endtask

  task automatic wait_addr(input int a, input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      if (Busy && !Done && Wr_Addr == 4'(a)) break;
      step(1);
    end
    check(tag, 32'(k < 60), 1);
  endtask

  task automatic wait_done(input int n, input string tag);
    int k;
    for (k = 0; k < 80 && done_at.size() < n; k++) step(1);
    check(tag, 32'(done_at.size() >= n), 1);
  endtask

  int t0;

  initial begin
    Reset = 1'b1; Clear_Req = 3'b000; Stall = 1'b0;
    step(1);

    // Reset state
    do_reset();
    check("rst_busy", 32'(Busy), 0);
    check("rst_wr_en", 32'(Wr_En), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_status", 32'(Clear_Status), 0);

    // 1: single pulse, latency and full address coverage
    mon_clear();
    t0 = cyc;
    pulse_req(3'b001);
    step(25);
    check("t1_first_wr", 32'(first_wr - t0), 2);
    check("t1_first_addr", 32'(first_addr), 0);
    check("t1_wr_cycles", 32'(wr_cycles), 16);
    check("t1_once0", 32'(once_cnt(0)), 16);
    check("t1_other", 32'(tot_cnt(1) + tot_cnt(2)), 0);
    check("t1_done_n", 32'(done_at.size()), 1);
    if (done_at.size() > 0) check("t1_done_at", 32'(done_at[0] - t0), 18);
    check("t1_status", 32'(Clear_Status), 3'b001);
    check("t1_data", 32'(data_bad), 0);
    check("t1_busy", 32'(Busy), 0);

    // 2: level held high gives one sweep only
    do_reset();
    mon_clear();
    Clear_Req = 3'b101;
    step(40);
    Clear_Req = 3'b000;
    step(5);
    check("t2_sweeps", 32'(sweep_mask.size()), 1);
    if (sweep_mask.size() > 0) check("t2_mask", 32'(sweep_mask[0]), 3'b101);
    check("t2_done_n", 32'(done_at.size()), 1);
    check("t2_once0", 32'(once_cnt(0)), 16);
    check("t2_once2", 32'(once_cnt(2)), 16);
    check("t2_status", 32'(Clear_Status), 3'b101);

    // 3: request mid-sweep is queued for the next sweep
    do_reset();
    mon_clear();
    pulse_req(3'b001);
    wait_addr(5, "t3_reach5");
    pulse_req(3'b010);
    wait_done(2, "t3_wait_done");
    step(2);
    check("t3_done_n", 32'(done_at.size()), 2);
    check("t3_sweeps", 32'(sweep_mask.size()), 2);
    if (sweep_mask.size() == 2) begin
      check("t3_mask0", 32'(sweep_mask[0]), 3'b001);
      check("t3_mask1", 32'(sweep_mask[1]), 3'b010);
      check("t3_gap", 32'(sweep_start[1] - done_at[0]), 2);
    end
    check("t3_once0", 32'(once_cnt(0)), 16);
    check("t3_once1", 32'(once_cnt(1)), 16);
    check("t3_status", 32'(Clear_Status), 3'b011);
    check("t3_outside", 32'(outside), 0);

    // 4: stall holds the address for three cycles
    do_reset();
    mon_clear();
    pulse_req(3'b001);
    wait_addr(7, "t4_reach7");
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_stall_en", 32'(Wr_En), 0);
      check("t4_stall_addr", 32'(Wr_Addr), 7);
      step(1);
    end
    Stall = 1'b0;
    wait_done(1, "t4_wait_done");
    step(2);
    check("t4_sweep_cyc", 32'(sweep_cyc), 19);
    check("t4_wr_cycles", 32'(wr_cycles), 16);
    check("t4_once0", 32'(once_cnt(0)), 16);
    check("t4_status", 32'(Clear_Status), 3'b001);

    // 5: re-request during own sweep keeps status low until the second sweep
    do_reset();
    mon_clear();
    pulse_req(3'b001);
    wait_addr(10, "t5_reach10");
    pulse_req(3'b001);
    wait_done(1, "t5_wait_done1");
    check("t5_status_mid", 32'(Clear_Status), 3'b000);
    wait_done(2, "t5_wait_done2");
    step(1);
    check("t5_status_end", 32'(Clear_Status), 3'b001);
    check("t5_sweeps", 32'(sweep_mask.size()), 2);
    check("t5_tot0", 32'(tot_cnt(0)), 32);

    // 6: reset mid-sweep abandons it
    do_reset();
    pulse_req(3'b010);
    step(22);
    check("t6_pre_status", 32'(Clear_Status), 3'b010);
    mon_clear();
    pulse_req(3'b001);
    wait_addr(8, "t6_reach8");
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    #1;
    check("t6_busy", 32'(Busy), 0);
    check("t6_wr_en", 32'(Wr_En), 0);
    check("t6_status", 32'(Clear_Status), 0);
    step(20);
    check("t6_no_done", 32'(done_at.size()), 0);
    mon_clear();
    pulse_req(3'b001);
    step(25);
    check("t6_first_addr", 32'(first_addr), 0);
    check("t6_once0", 32'(once_cnt(0)), 16);
    check("t6_done_n", 32'(done_at.size()), 1);
    check("t6_status_end", 32'(Clear_Status), 3'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
